fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction queue entries and max in-flight requests (power of two, >=2).
REQ-003 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port RedirectValid  input  1  take RedirectPC (NextPClogic output) this cycle.
REQ-006 SHALL have port RedirectPC  input  64  redirect target; bits [1:0] treated as 00.
REQ-007 SHALL have port ImemReqValid  output  1  fetch request valid.
REQ-008 SHALL have port ImemReqAddr  output  64  fetch address.
REQ-009 SHALL have port ImemReqReady  input  1  memory accepts request.
REQ-010 SHALL have port ImemRspValid  input  1  in-order response valid; always accepted.
REQ-011 SHALL have port ImemRspData  input  32  instruction word.
REQ-012 SHALL have port InstValid  output  1  instruction available to decode.
REQ-013 SHALL have port Instruction  output  32  head instruction.
REQ-014 SHALL have port InstPC  output  64  address of head instruction (CurrentPC for NextPClogic).
REQ-015 SHALL have port InstReady  input  1  decode consumes head.

Function
REQ-016 SHALL transfer request on ImemReqValid&ImemReqReady and deliver on InstValid&InstReady; ImemReqAddr stable while ImemReqValid&!ImemReqReady unless redirected.
REQ-017 SHALL advance fetch PC by 64'h4 per accepted request, modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC wraps to 64'h0).
REQ-018 SHALL assert ImemReqValid only in FETCH with outstanding+queue_count < DEPTH.
REQ-019 SHALL record each accepted request address in order and pair it with its response as InstPC.
REQ-020 SHALL implement states FETCH and FLUSH.
REQ-021 FETCH: on RedirectValid, fetch PC <= {RedirectPC[63:2],2'b00}, queue emptied; next state FLUSH if post-edge outstanding>0, else FETCH.
REQ-022 FLUSH: no requests; every response discarded and decrements outstanding; return to FETCH when outstanding reaches 0; RedirectValid in FLUSH updates fetch PC, stays FLUSH.
REQ-023 Redirect same cycle as request handshake: request counts outstanding, its response discarded; fetch PC = redirect target, not +4.
REQ-024 Redirect same cycle as response: response discarded.
REQ-025 Redirect same cycle as InstValid&InstReady: head delivery completes; remaining entries flushed.
REQ-026 Without bypass, response enters queue; InstValid earliest the cycle after ImemRspValid.
REQ-027 Response arriving when queue full SHALL not occur by construction (credit rule REQ-018); no overflow/underflow under any input.

Reset
REQ-028 Reset SHALL set fetch PC=RESET_PC, state FETCH, outstanding=0, queue empty, InstValid=0, ImemReqValid=0, Instruction=0, InstPC=0.
REQ-029 Reset mid-operation SHALL abandon all in-flight requests; responses during Reset ignored; memory is reset concurrently.
REQ-030 First cycle after Reset deasserts SHALL drive ImemReqValid=1, ImemReqAddr=RESET_PC.

Configuration
REQ-031 Macro FETCH_BYPASS_EN defined: response arriving in FETCH with queue empty and no redirect drives InstValid/Instruction/InstPC combinationally same cycle; if InstReady, not enqueued.
REQ-032 FETCH_BYPASS_EN undefined: REQ-026 latency always applies; no combinational path from ImemRsp* to Inst*.

Structure
REQ-033 Package fetch_pkg SHALL hold fetch_state_t, INST_W=32, ADDR_W=64, PC_INCR=64'h4, and entry struct {pc, inst}.
REQ-034 Queue SHALL be sub-module fetch_fifo (parameterised DEPTH, entry type, flush input), instantiated once for entries; address tracker may reuse it.

Verification
REQ-035 Reset with RESET_PC=64'h10, ImemReqReady=1, 1-cycle memory -> addresses 64'h10,14,18; InstPC 64'h10,14 in order.
REQ-036 InstReady=0, DEPTH=2 -> exactly 2 requests issued then ImemReqValid=0 until InstReady=1.
REQ-037 Two outstanding, RedirectValid with RedirectPC=64'h20 -> FLUSH, both responses dropped, next request addr 64'h20, first InstPC 64'h20.
REQ-038 RedirectPC=64'h23 -> ImemReqAddr 64'h20.
REQ-039 Redirect to 64'hFFFF_FFFF_FFFF_FFFC -> next request addr 64'h0.
REQ-040 FETCH_BYPASS_EN defined, queue empty, response 32'hF8000000 with InstReady=1 -> InstValid same cycle, queue stays empty; undefined -> InstValid one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 64;
  localparam logic [ADDR_W-1:0] PC_INCR = 64'h4;

  // Fetch control states: FETCH issues requests, FLUSH drains stale responses.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  // One instruction queue entry: the fetched word and the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned; the low two bits of any target are ignored.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory request/response bus.
// master = fetch unit side, slave = memory side.
interface fetch_if;

  logic                           ImemReqValid;
  logic [fetch_pkg::ADDR_W-1:0]   ImemReqAddr;
  logic                           ImemReqReady;
  logic                           ImemRspValid;
  logic [fetch_pkg::INST_W-1:0]   ImemRspData;

  modport master (
    output ImemReqValid,
    output ImemReqAddr,
    input  ImemReqReady,
    input  ImemRspValid,
    input  ImemRspData
  );

  modport slave (
    input  ImemReqValid,
    input  ImemReqAddr,
    output ImemReqReady,
    output ImemRspValid,
    output ImemRspData
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush. Push when full and pop when
// empty are ignored so the storage can never overflow or underflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  // Qualify push/pop against occupancy and flush.
  always_comb begin
    w_push = i_push && !i_flush && (r_cnt != DEPTH_C);
    w_pop  = i_pop  && !i_flush && (r_cnt != CW'(0));
  end

  // Pointer and occupancy tracking; reset and flush both empty the FIFO.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd  <= AW'(0);
      r_wr  <= AW'(0);
      r_cnt <= CW'(0);
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited requests,
// redirect/flush handling and an instruction queue toward decode.
// Optional feature: define FETCH_BYPASS_EN to let a response that finds the
// queue empty reach decode combinationally in the same cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter int                DEPTH    = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              RedirectValid,
  input  logic [ADDR_W-1:0] RedirectPC,
  fetch_if.master           imem,
  output logic              InstValid,
  output logic [INST_W-1:0] Instruction,
  output logic [ADDR_W-1:0] InstPC,
  input  logic              InstReady
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [ADDR_W-1:0] r_pc;

  logic [CW-1:0]     w_trk_cnt;
  logic [ADDR_W-1:0] w_trk_head;
  logic [CW-1:0]     w_q_cnt;
  fetch_entry_t      w_q_head;
  fetch_entry_t      w_q_in;

  logic [CW:0]       w_inflight;
  logic [CW-1:0]     w_out_next;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp_fire;
  logic              w_bypass;
  logic              w_q_push;
  logic              w_q_pop;
  logic              w_q_flush;

  // Credit and handshake qualification shared by the FSM and datapath.
  always_comb begin
    w_inflight  = {1'b0, w_trk_cnt} + {1'b0, w_q_cnt};
    w_req_valid = !Reset && (r_state == FETCH) && (w_inflight < DEPTH_L);
    w_req_fire  = w_req_valid && imem.ImemReqReady;
    w_rsp_fire  = !Reset && imem.ImemRspValid && (w_trk_cnt != CW'(0));
    w_out_next  = w_trk_cnt + CW'(w_req_fire) - CW'(w_rsp_fire);
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (Reset) r_state <= FETCH;
    else       r_state <= w_next_state;
  end

  // FSM next state: a redirect with requests still in flight drains them first.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH: begin
        if (RedirectValid) w_next_state = (w_out_next != CW'(0)) ? FLUSH : FETCH;
        else               w_next_state = FETCH;
      end
      FLUSH: begin
        if (w_out_next == CW'(0)) w_next_state = FETCH;
        else                      w_next_state = FLUSH;
      end
      default: w_next_state = FETCH;
    endcase
  end

  // FSM outputs: queue control, bypass select and decode-facing outputs.
  always_comb begin
`ifdef FETCH_BYPASS_EN
    w_bypass = (r_state == FETCH) && (w_q_cnt == CW'(0)) && !RedirectValid && w_rsp_fire;
`else
    w_bypass = 1'b0;
`endif
    w_q_flush = RedirectValid;
    w_q_pop   = InstReady && (w_q_cnt != CW'(0));
    w_q_push  = w_rsp_fire && (r_state == FETCH) && !RedirectValid && !(w_bypass && InstReady);
    w_q_in    = '{pc: w_trk_head, inst: imem.ImemRspData};
    if (w_q_cnt != CW'(0)) begin
      InstValid   = 1'b1;
      Instruction = w_q_head.inst;
      InstPC      = w_q_head.pc;
`ifdef FETCH_BYPASS_EN
    end else if (w_bypass) begin
      InstValid   = 1'b1;
      Instruction = imem.ImemRspData;
      InstPC      = w_trk_head;
`endif
    end else begin
      InstValid   = 1'b0;
      Instruction = 32'h0;
      InstPC      = 64'h0;
    end
  end

  // Fetch PC: redirect wins over the +4 advance of an accepted request.
  always_ff @(posedge CLK) begin
    if (Reset)              r_pc <= RESET_PC;
    else if (RedirectValid) r_pc <= align_pc(RedirectPC);
    else if (w_req_fire)    r_pc <= r_pc + PC_INCR;
    else                    r_pc <= r_pc;
  end

  assign imem.ImemReqValid = w_req_valid;
  assign imem.ImemReqAddr  = r_pc;

  // Addresses of outstanding requests, in issue order; its count is the
  // outstanding total and its head pairs with the next response.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [ADDR_W-1:0])
  ) u_trk (
    .i_clk   (CLK),
    .i_rst   (Reset),
    .i_flush (1'b0),
    .i_push  (w_req_fire),
    .i_data  (r_pc),
    .i_pop   (w_rsp_fire),
    .o_head  (w_trk_head),
    .o_count (w_trk_cnt)
  );

  // Instruction queue toward decode.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_queue (
    .i_clk   (CLK),
    .i_rst   (Reset),
    .i_flush (w_q_flush),
    .i_push  (w_q_push),
    .i_data  (w_q_in),
    .i_pop   (w_q_pop),
    .o_head  (w_q_head),
    .o_count (w_q_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
// (RESET_PC = 64'h10, DEPTH = 2, 1-cycle memory model).
module tb_fetch_unit;

  logic        CLK;
  logic        rst;
  logic        redir_valid;
  logic [63:0] redir_pc;
  logic        inst_ready;
  logic        req_ready;
  logic        InstValid;
  logic [31:0] Instruction;
  logic [63:0] InstPC;

  logic        mem_auto;
  logic        hold;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        man_rsp_valid;
  logic [31:0] man_rsp_data;
  logic [63:0] pend [$];
  logic [63:0] tmp;
  logic [63:0] req_log [$];
  logic [63:0] del_pc [$];
  logic [31:0] del_inst [$];

  int checks;
  int errors;

  fetch_if bus ();

  assign bus.ImemReqReady = req_ready;
  assign bus.ImemRspValid = mem_auto ? mem_rsp_valid : man_rsp_valid;
  assign bus.ImemRspData  = mem_auto ? mem_rsp_data  : man_rsp_data;

  fetch_unit #(.RESET_PC(64'h10), .DEPTH(2)) dut (
    .CLK           (CLK),
    .Reset         (rst),
    .RedirectValid (redir_valid),
    .RedirectPC    (redir_pc),
    .imem          (bus.master),
    .InstValid     (InstValid),
    .Instruction   (Instruction),
    .InstPC        (InstPC),
    .InstReady     (inst_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: responds one cycle after acceptance with {8'hA5, addr[23:0]}.
  always @(posedge CLK) begin
    if (rst) begin
      pend.delete();
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= 32'h0;
    end else begin
      if (mem_auto && mem_rsp_valid && pend.size() > 0) tmp = pend.pop_front();
      if (bus.ImemReqValid && req_ready) pend.push_back(bus.ImemReqAddr);
      if (pend.size() > 0) begin
        mem_rsp_valid <= !hold;
        mem_rsp_data  <= {8'hA5, pend[0][23:0]};
      end else begin
        mem_rsp_valid <= 1'b0;
        mem_rsp_data  <= 32'h0;
      end
    end
  end

  // Log accepted requests and delivered instructions.
  always @(posedge CLK) begin
    if (!rst) begin
      if (bus.ImemReqValid && req_ready) req_log.push_back(bus.ImemReqAddr);
      if (InstValid && inst_ready) begin
        del_pc.push_back(InstPC);
        del_inst.push_back(Instruction);
      end
    end
  end

  task automatic do_reset;
    @(negedge CLK);
    rst = 1'b1;
    redir_valid = 1'b0;
    man_rsp_valid = 1'b0;
    repeat (2) @(negedge CLK);
    req_log.delete();
    del_pc.delete();
    del_inst.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    checks++; if (bus.ImemReqValid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %0h exp 0", bus.ImemReqValid); end
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %0h exp 0", InstValid); end
    checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL rst_instruction got %h exp 0", Instruction); end
    checks++; if (InstPC !== 64'h0) begin errors++; $display("FAIL rst_inst_pc got %h exp 0", InstPC); end
    rst = 1'b0;
    #1;
    checks++; if (bus.ImemReqValid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %0h exp 1", bus.ImemReqValid); end
    checks++; if (bus.ImemReqAddr !== 64'h10) begin errors++; $display("FAIL first_req_addr got %h exp 10", bus.ImemReqAddr); end
  endtask

  task automatic test_stream;
    req_ready = 1'b1; inst_ready = 1'b1; hold = 1'b0; mem_auto = 1'b1;
    do_reset();
    repeat (8) @(negedge CLK);
    if (req_log.size() < 3) begin
      checks++; errors++; $display("FAIL stream_req_count got %0d exp >=3", req_log.size());
    end else begin
      checks++; if (req_log[0] !== 64'h10) begin errors++; $display("FAIL stream_req0 got %h exp 10", req_log[0]); end
      checks++; if (req_log[1] !== 64'h14) begin errors++; $display("FAIL stream_req1 got %h exp 14", req_log[1]); end
      checks++; if (req_log[2] !== 64'h18) begin errors++; $display("FAIL stream_req2 got %h exp 18", req_log[2]); end
    end
    if (del_pc.size() < 2) begin
      checks++; errors++; $display("FAIL stream_del_count got %0d exp >=2", del_pc.size());
    end else begin
      checks++; if (del_pc[0] !== 64'h10) begin errors++; $display("FAIL stream_pc0 got %h exp 10", del_pc[0]); end
      checks++; if (del_pc[1] !== 64'h14) begin errors++; $display("FAIL stream_pc1 got %h exp 14", del_pc[1]); end
      checks++; if (del_inst[0] !== 32'hA500_0010) begin errors++; $display("FAIL stream_inst0 got %h exp a5000010", del_inst[0]); end
      checks++; if (del_inst[1] !== 32'hA500_0014) begin errors++; $display("FAIL stream_inst1 got %h exp a5000014", del_inst[1]); end
    end
  endtask

  task automatic test_stall;
    req_ready = 1'b1; inst_ready = 1'b0; hold = 1'b0; mem_auto = 1'b1;
    do_reset();
    repeat (8) @(negedge CLK);
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL stall_req_count got %0d exp 2", req_log.size()); end
    checks++; if (bus.ImemReqValid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got %0h exp 0", bus.ImemReqValid); end
    checks++; if (InstValid !== 1'b1 || InstPC !== 64'h10) begin errors++; $display("FAIL stall_head got v%0h pc %h exp v1 pc 10", InstValid, InstPC); end
    inst_ready = 1'b1;
    @(negedge CLK);
    checks++; if (bus.ImemReqValid !== 1'b1 || bus.ImemReqAddr !== 64'h18) begin errors++; $display("FAIL stall_resume got v%0h addr %h exp v1 addr 18", bus.ImemReqValid, bus.ImemReqAddr); end
  endtask

  task automatic test_redirect_flush;
    req_ready = 1'b1; inst_ready = 1'b1; hold = 1'b1; mem_auto = 1'b1;
    do_reset();
    repeat (2) @(negedge CLK);
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL flush_outstanding got %0d exp 2", req_log.size()); end
    req_log.delete();
    redir_valid = 1'b1; redir_pc = 64'h20;
    @(negedge CLK);
    redir_valid = 1'b0; hold = 1'b0;
    checks++; if (bus.ImemReqValid !== 1'b0) begin errors++; $display("FAIL flush_no_req got %0h exp 0", bus.ImemReqValid); end
    @(negedge CLK);
    checks++; if (bus.ImemReqValid !== 1'b0) begin errors++; $display("FAIL flush_no_req2 got %0h exp 0", bus.ImemReqValid); end
    repeat (10) @(negedge CLK);
    if (req_log.size() < 1 || del_pc.size() < 1) begin
      checks++; errors++; $display("FAIL flush_progress got req %0d del %0d exp >=1", req_log.size(), del_pc.size());
    end else begin
      checks++; if (req_log[0] !== 64'h20) begin errors++; $display("FAIL flush_next_addr got %h exp 20", req_log[0]); end
      checks++; if (del_pc[0] !== 64'h20) begin errors++; $display("FAIL flush_first_pc got %h exp 20", del_pc[0]); end
      checks++; if (del_inst[0] !== 32'hA500_0020) begin errors++; $display("FAIL flush_first_inst got %h exp a5000020", del_inst[0]); end
    end
  endtask

  task automatic test_redirect_handshake;
    req_ready = 1'b1; inst_ready = 1'b1; hold = 1'b0; mem_auto = 1'b1;
    do_reset();
    redir_valid = 1'b1; redir_pc = 64'h40;
    @(negedge CLK);
    redir_valid = 1'b0;
    checks++; if (bus.ImemReqValid !== 1'b0) begin errors++; $display("FAIL hs_flush_no_req got %0h exp 0", bus.ImemReqValid); end
    @(negedge CLK);
    checks++; if (bus.ImemReqValid !== 1'b1 || bus.ImemReqAddr !== 64'h40) begin errors++; $display("FAIL hs_next_req got v%0h addr %h exp v1 addr 40", bus.ImemReqValid, bus.ImemReqAddr); end
    repeat (6) @(negedge CLK);
    if (del_pc.size() < 1) begin
      checks++; errors++; $display("FAIL hs_del_count got %0d exp >=1", del_pc.size());
    end else begin
      checks++; if (del_pc[0] !== 64'h40) begin errors++; $display("FAIL hs_first_pc got %h exp 40", del_pc[0]); end
    end
  endtask

  task automatic test_redirect_align;
    req_ready = 1'b0; inst_ready = 1'b1; hold = 1'b0; mem_auto = 1'b1;
    do_reset();
    @(negedge CLK);
    checks++; if (bus.ImemReqValid !== 1'b1 || bus.ImemReqAddr !== 64'h10) begin errors++; $display("FAIL align_stable got v%0h addr %h exp v1 addr 10", bus.ImemReqValid, bus.ImemReqAddr); end
    redir_valid = 1'b1; redir_pc = 64'h23;
    @(negedge CLK);
    checks++; if (bus.ImemReqAddr !== 64'h20) begin errors++; $display("FAIL align_addr got %h exp 20", bus.ImemReqAddr); end
    redir_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge CLK);
    redir_valid = 1'b0;
    checks++; if (bus.ImemReqAddr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h exp fffffffffffffffc", bus.ImemReqAddr); end
    req_ready = 1'b1;
    @(negedge CLK);
    req_ready = 1'b0;
    checks++; if (bus.ImemReqValid !== 1'b1 || bus.ImemReqAddr !== 64'h0) begin errors++; $display("FAIL wrap_zero got v%0h addr %h exp v1 addr 0", bus.ImemReqValid, bus.ImemReqAddr); end
    repeat (4) @(negedge CLK);
    if (del_pc.size() < 1) begin
      checks++; errors++; $display("FAIL wrap_del_count got %0d exp >=1", del_pc.size());
    end else begin
      checks++; if (del_pc[0] !== 64'hFFFF_FFFF_FFFF_FFFC || del_inst[0] !== 32'hA5FF_FFFC) begin errors++; $display("FAIL wrap_del got pc %h inst %h exp fffffffffffffffc a5fffffc", del_pc[0], del_inst[0]); end
    end
  endtask

  task automatic test_bypass;
    req_ready = 1'b1; inst_ready = 1'b1; hold = 1'b0; mem_auto = 1'b0;
    do_reset();
    @(negedge CLK);
    req_ready = 1'b0;
    man_rsp_valid = 1'b1; man_rsp_data = 32'hF800_0000;
    #1;
`ifdef FETCH_BYPASS_EN
    checks++; if (InstValid !== 1'b1 || Instruction !== 32'hF800_0000 || InstPC !== 64'h10) begin errors++; $display("FAIL bypass_same_cycle got v%0h inst %h pc %h exp v1 f8000000 10", InstValid, Instruction, InstPC); end
`else
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL nobypass_same_cycle got v%0h exp v0", InstValid); end
`endif
    @(negedge CLK);
    man_rsp_valid = 1'b0;
    #1;
`ifdef FETCH_BYPASS_EN
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL bypass_queue_empty got v%0h exp v0", InstValid); end
`else
    checks++; if (InstValid !== 1'b1 || Instruction !== 32'hF800_0000 || InstPC !== 64'h10) begin errors++; $display("FAIL nobypass_next_cycle got v%0h inst %h pc %h exp v1 f8000000 10", InstValid, Instruction, InstPC); end
`endif
    @(negedge CLK);
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL bypass_drained got v%0h exp v0", InstValid); end
    checks++; if (del_pc.size() != 1) begin errors++; $display("FAIL bypass_del_count got %0d exp 1", del_pc.size()); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; redir_valid = 1'b0; redir_pc = 64'h0;
    inst_ready = 1'b1; req_ready = 1'b1;
    mem_auto = 1'b1; hold = 1'b0;
    man_rsp_valid = 1'b0; man_rsp_data = 32'h0;
    tmp = 64'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_handshake();
    test_redirect_align();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
